// File: rtl/draw_clear_sequencer_pkg.sv
// Shared definitions for the stage-clear overlay sequencer: state encoding,
// overlay geometry and the default draw timeout.
package draw_clear_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARM     = 3'd1,
        DRAW    = 3'd2,
        SHOW    = 3'd3,
        ADVANCE = 3'd4,
        FAULT   = 3'd5
    } state_t;

    localparam int CLEAR_W         = 80;
    localparam int CLEAR_H         = 40;
    localparam int CLEAR_PIXELS    = CLEAR_W * CLEAR_H;
    localparam int CLEAR_X_OFF     = 39;
    localparam int CLEAR_Y_OFF     = 39;
    localparam int DEFAULT_TIMEOUT = 4095;

    localparam int CNT_W    = 12;
    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 9;

endpackage

// File: rtl/draw_clear_sequencer_if.sv
// Drawer and VGA-adapter signals of the overlay sequencer. The master side is
// the sequencer; the slave side is the drawer / VGA adapter pair.
interface draw_clear_sequencer_if;
    import draw_clear_sequencer_pkg::*;

    logic                draw_resetn;
    logic                draw_done;
    logic [X_W-1:0]      draw_x;
    logic [Y_W-1:0]      draw_y;
    logic [COLOUR_W-1:0] draw_colour;

    logic [X_W-1:0]      vga_x;
    logic [Y_W-1:0]      vga_y;
    logic [COLOUR_W-1:0] vga_colour;
    logic                vga_plot;

    modport master (
        output draw_resetn, vga_x, vga_y, vga_colour, vga_plot,
        input  draw_done, draw_x, draw_y, draw_colour
    );

    modport slave (
        input  draw_resetn, vga_x, vga_y, vga_colour, vga_plot,
        output draw_done, draw_x, draw_y, draw_colour
    );

endinterface

// File: rtl/draw_clear_sequencer_key_edge_detect.sv
// Registered rising-edge detector for the player's "next stage" key. The
// history register resets to 1 so a key already held out of reset never fires.
module key_edge_detect (
    input  logic clk,
    input  logic resetn,
    input  logic key,
    output logic rise
);

    logic key_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            key_q <= 1'b1;
        end else begin
            key_q <= key;
        end
    end

    assign rise = key & ~key_q;

endmodule

// File: rtl/draw_clear_sequencer.sv
// Sequences the stage-clear overlay: releases the drawer, forwards its pixels
// to the VGA adapter, shows the overlay and waits for the player to advance.
module draw_clear_sequencer
    import draw_clear_sequencer_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  stage_clear,
    input  logic                  next_stage_req,
    draw_clear_sequencer_if.master bus,
    output logic                  busy,
    output logic                  overlay_shown,
    output logic                  advance,
    output logic                  error
);

    // Counter value during the last DRAW cycle allowed before giving up.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] draw_cnt;
    logic             key_rise;

    key_edge_detect u_key_edge (
        .clk    (clk),
        .resetn (resetn),
        .key    (next_stage_req),
        .rise   (key_rise)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Cleared in ARM so it reads zero on the first DRAW cycle.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            draw_cnt <= '0;
        end else if (state_q == ARM) begin
            draw_cnt <= '0;
        end else if (state_q == DRAW) begin
            draw_cnt <= draw_cnt + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (stage_clear) state_d = ARM;
            ARM:     state_d = DRAW;
            DRAW: begin
                if (bus.draw_done) begin
                    state_d = SHOW;
                end else if (draw_cnt == LAST_CNT) begin
                    state_d = FAULT;
                end
            end
            SHOW:    if (key_rise) state_d = ADVANCE;
            ADVANCE: state_d = IDLE;
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    // Drawer pixels reach the VGA adapter only while drawing.
    always_comb begin
        bus.draw_resetn = 1'b0;
        bus.vga_plot    = 1'b0;
        bus.vga_x       = '0;
        bus.vga_y       = '0;
        bus.vga_colour  = '0;
        busy            = 1'b0;
        overlay_shown   = 1'b0;
        advance         = 1'b0;
        error           = 1'b0;
        unique case (state_q)
            ARM: begin
                bus.draw_resetn = 1'b1;
                busy            = 1'b1;
            end
            DRAW: begin
                bus.draw_resetn = 1'b1;
                bus.vga_plot    = 1'b1;
                bus.vga_x       = bus.draw_x;
                bus.vga_y       = bus.draw_y;
                bus.vga_colour  = bus.draw_colour;
                busy            = 1'b1;
            end
            SHOW:    overlay_shown = 1'b1;
            ADVANCE: begin
                advance = 1'b1;
                busy    = 1'b1;
            end
            FAULT:   error = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_draw_clear_sequencer.sv
// Directed bench: a behavioural 80x40 drawer feeds the sequencer while a
// scoreboard checks every plotted pixel; a second instance covers the timeout.
module tb_draw_clear_sequencer;

    localparam int CW = draw_clear_sequencer_pkg::CLEAR_W;
    localparam int NPIX = draw_clear_sequencer_pkg::CLEAR_PIXELS;
    localparam int XO = draw_clear_sequencer_pkg::CLEAR_X_OFF;
    localparam int YO = draw_clear_sequencer_pkg::CLEAR_Y_OFF;

    logic clk = 1'b0;
    logic resetn, stage_clear, next_stage_req, force_done;
    logic busy, overlay_shown, advance, error;
    logic stage_clear2;
    logic busy2, overlay_shown2, advance2, error2;

    int total = 0;
    int bad = 0;
    logic [23:0] expQ[$];

    draw_clear_sequencer_if bus ();
    draw_clear_sequencer_if bus2 ();

    always #5 clk = ~clk;

    draw_clear_sequencer dut (
        .clk            (clk),
        .resetn         (resetn),
        .stage_clear    (stage_clear),
        .next_stage_req (next_stage_req),
        .bus            (bus),
        .busy           (busy),
        .overlay_shown  (overlay_shown),
        .advance        (advance),
        .error          (error)
    );

    draw_clear_sequencer #(.TIMEOUT(100)) dut2 (
        .clk            (clk),
        .resetn         (resetn),
        .stage_clear    (stage_clear2),
        .next_stage_req (1'b0),
        .bus            (bus2),
        .busy           (busy2),
        .overlay_shown  (overlay_shown2),
        .advance        (advance2),
        .error          (error2)
    );

    // Drawer model: one cycle of reset synchronisation, then the first pixel
    // is held for an extra cycle before sweeping the rectangle row by row.
    int p = 0;
    bit started = 1'b0;
    bit rstQ = 1'b0;

    always @(posedge clk) begin
        rstQ <= bus.draw_resetn;
        if (!rstQ) begin
            p <= 0;
            started <= 1'b0;
        end else if (!started) begin
            started <= 1'b1;
        end else if (p < NPIX - 1) begin
            p <= p + 1;
        end
    end

    assign bus.draw_x      = 8'(p % CW + XO);
    assign bus.draw_y      = 7'(p / CW + YO);
    assign bus.draw_colour = 9'(p * 37 + 5);
    assign bus.draw_done   = (started && p == NPIX - 1) || force_done;

    assign bus2.draw_done   = 1'b0;
    assign bus2.draw_x      = 8'd50;
    assign bus2.draw_y      = 7'd20;
    assign bus2.draw_colour = 9'h155;

    function automatic logic [23:0] pixelOf(int i);
        return {8'(i % CW + XO), 7'(i / CW + YO), 9'(i * 37 + 5)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic sc, input logic key, input logic rn);
        stage_clear = sc;
        next_stage_req = key;
        resetn = rn;
    endtask

    task automatic nextCycle();
        @(negedge clk);
    endtask

    task automatic pushDraw();
        expQ.push_back(pixelOf(0));
        for (int i = 0; i < NPIX; i++) expQ.push_back(pixelOf(i));
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_ctl"}, {bus.draw_resetn, bus.vga_plot, busy, overlay_shown, advance, error}, 0);
        checkOutput({tag, "_pix"}, {bus.vga_x, bus.vga_y, bus.vga_colour}, 0);
    endtask

    // Runs DRAW until the overlay appears, optionally pulsing stage_clear
    // at a given plot count; returns the number of plotted cycles.
    task automatic waitShow(input int injectAt, output int n);
        n = 0;
        for (int i = 0; i < 4000; i++) begin
            nextCycle();
            if (overlay_shown) break;
            if (bus.vga_plot) n++;
            stage_clear = (injectAt != 0 && n == injectAt);
        end
        stage_clear = 1'b0;
        checkOutput("show_reached", overlay_shown, 1);
    endtask

    always @(negedge clk) begin
        if (bus.vga_plot === 1'b1) begin
            checkOutput("plot_pending", 32'(expQ.size() != 0), 1);
            if (expQ.size() != 0) checkOutput("pixel", {bus.vga_x, bus.vga_y, bus.vga_colour}, expQ.pop_front());
        end
    end

    initial begin
        int n;
        force_done = 1'b0;
        stage_clear2 = 1'b0;
        applyStimulus(0, 0, 0);
        repeat (3) nextCycle();
        checkIdle("reset");
        applyStimulus(0, 0, 1);
        nextCycle();
        checkIdle("idle");

        force_done = 1'b1;
        repeat (2) nextCycle();
        checkIdle("done_in_idle");
        force_done = 1'b0;

        $display("[TB] full draw with stray stage_clear pulses");
        pushDraw();
        applyStimulus(1, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 1);
        checkOutput("arm_ctl", {bus.draw_resetn, bus.vga_plot, busy, overlay_shown}, 4'b1010);
        waitShow(500, n);
        checkOutput("draw_len", n, 3201);
        checkOutput("queue_empty", expQ.size(), 0);
        checkOutput("show_ctl", {bus.draw_resetn, bus.vga_plot, busy, error, advance}, 0);
        checkOutput("show_pix", {bus.vga_x, bus.vga_y, bus.vga_colour}, 0);
        applyStimulus(1, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 1);
        repeat (3) nextCycle();
        checkOutput("show_sc_ignored", {overlay_shown, busy}, 2'b10);
        applyStimulus(0, 1, 1);
        nextCycle();
        checkOutput("advance_pulse", {advance, busy, overlay_shown}, 3'b110);
        nextCycle();
        checkOutput("advance_done", {advance, busy, overlay_shown}, 0);
        applyStimulus(0, 0, 1);
        nextCycle();

        $display("[TB] key held through draw");
        pushDraw();
        applyStimulus(1, 1, 1);
        nextCycle();
        applyStimulus(0, 1, 1);
        waitShow(0, n);
        checkOutput("draw_len_held", n, 3201);
        for (int i = 0; i < 4; i++) begin
            nextCycle();
            checkOutput("held_no_adv", {advance, overlay_shown}, 2'b01);
        end
        applyStimulus(0, 0, 1);
        nextCycle();
        checkOutput("released_show", {advance, overlay_shown}, 2'b01);
        applyStimulus(0, 1, 1);
        nextCycle();
        checkOutput("repress_adv", advance, 1);
        applyStimulus(0, 0, 1);
        nextCycle();
        checkOutput("repress_idle", {advance, busy, overlay_shown}, 0);

        $display("[TB] reset mid-draw");
        pushDraw();
        applyStimulus(1, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 1);
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            nextCycle();
            if (bus.vga_plot) n++;
            if (n == 500) break;
        end
        checkOutput("abort_at", n, 500);
        applyStimulus(0, 0, 0);
        nextCycle();
        checkIdle("abort");
        expQ.delete();
        applyStimulus(0, 0, 1);
        nextCycle();
        pushDraw();
        applyStimulus(1, 0, 1);
        nextCycle();
        applyStimulus(0, 0, 1);
        waitShow(0, n);
        checkOutput("draw_len_redraw", n, 3201);
        checkOutput("queue_empty_redraw", expQ.size(), 0);
        applyStimulus(0, 1, 1);
        nextCycle();
        checkOutput("redraw_adv", advance, 1);
        applyStimulus(0, 0, 1);
        nextCycle();

        $display("[TB] timeout with silent drawer");
        stage_clear2 = 1'b1;
        nextCycle();
        stage_clear2 = 1'b0;
        checkOutput("to_arm", {busy2, bus2.draw_resetn, bus2.vga_plot}, 3'b110);
        n = 0;
        for (int i = 0; i < 300; i++) begin
            nextCycle();
            if (error2) break;
            if (bus2.vga_plot) begin
                n++;
                if (n == 1) checkOutput("to_pixel", {bus2.vga_x, bus2.vga_y, bus2.vga_colour}, {8'd50, 7'd20, 9'h155});
            end
        end
        checkOutput("to_len", n, 100);
        checkOutput("to_fault", {error2, bus2.vga_plot, bus2.draw_resetn, busy2, overlay_shown2}, 5'b10000);
        stage_clear2 = 1'b1;
        nextCycle();
        stage_clear2 = 1'b0;
        repeat (3) nextCycle();
        checkOutput("to_sticky", {error2, busy2, advance2}, 3'b100);
        applyStimulus(0, 0, 0);
        nextCycle();
        applyStimulus(0, 0, 1);
        checkOutput("to_reset", {error2, busy2, bus2.vga_plot}, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
